// File: rtl/adder_pkg.sv
// Shared types and default widths for the adder result path.
//   DATA_W_DEF   : adder sum width
//   ACC_W_DEF    : running accumulator width
//   DEPTH_DEF    : result FIFO depth (power of two, >= 2)
//   OVF_W        : overflow counter width
//   entry_t      : one captured adder result {ovf, sum}
//   fifo_state_e : occupancy FSM states
package adder_pkg;

  localparam int unsigned DATA_W_DEF = 4;
  localparam int unsigned ACC_W_DEF  = 8;
  localparam int unsigned DEPTH_DEF  = 4;
  localparam int unsigned OVF_W      = 4;

  typedef struct packed {
    logic                  ovf;
    logic [DATA_W_DEF-1:0] sum;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    MID   = 2'd1,
    FULL  = 2'd2
  } fifo_state_e;

endpackage

// File: rtl/result_fifo.sv
// First-word fall-through FIFO for adder results with an explicit occupancy FSM.
//   clk, rst_n  : clock, asynchronous active-low reset
//   push, pop   : write / read strobes (ignored when FULL / EMPTY)
//   wr_entry    : entry written at the write pointer
//   rd_entry_c  : head entry, read combinationally from storage
//   not_full_c  : decoded from the state register, no path from pop
//   not_empty_c : decoded from the state register
//   level       : registered occupancy
module result_fifo
  import adder_pkg::*;
#(
  parameter  int unsigned DEPTH = DEPTH_DEF,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  entry_t           wr_entry,
  output entry_t           rd_entry_c,
  output logic             not_full_c,
  output logic             not_empty_c,
  output logic [LVL_W-1:0] level
);

  fifo_state_e      state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0] level_d;
  entry_t           mem_q [DEPTH];
  logic             wr_fire, rd_fire;

  assign wr_fire = push && (state_q != FULL);
  assign rd_fire = pop  && (state_q != EMPTY);

  assign not_full_c  = (state_q != FULL);
  assign not_empty_c = (state_q != EMPTY);
  assign rd_entry_c  = mem_q[rd_ptr_q];

  // State and occupancy registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      level   <= '0;
    end else begin
      state_q <= state_d;
      level   <= level_d;
    end
  end

  // Next state and next occupancy; push+pop together leaves both unchanged
  always_comb begin
    state_d = state_q;
    level_d = level;
    if (wr_fire && !rd_fire) begin
      level_d = level + LVL_W'(1);
    end else if (rd_fire && !wr_fire) begin
      level_d = level - LVL_W'(1);
    end
    case (state_q)
      EMPTY: begin
        if (wr_fire) state_d = MID;
      end
      MID: begin
        if (wr_fire && !rd_fire && (level == LVL_W'(DEPTH - 1))) begin
          state_d = FULL;
        end else if (rd_fire && !wr_fire && (level == LVL_W'(1))) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (rd_fire) state_d = MID;
      end
      default: state_d = EMPTY;
    endcase
  end

  // Storage and pointers; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (wr_fire) begin
        mem_q[wr_ptr_q] <= wr_entry;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (rd_fire) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
    end
  end

endmodule

// File: rtl/sum_accumulator.sv
// Buffers adder results in a small FIFO and folds each released entry into
// saturating statistics.
//   Clk, Rst_n            : clock, asynchronous active-low reset
//   In_valid/Sum/Overflow : adder result input, accepted when In_ready
//   Out_valid/Out_ready   : head handshake; Out_sum/Out_ovf show the head
//   Clr                   : synchronous clear of statistics (FIFO untouched)
//   Acc/Acc_sat           : saturating running total of released sums, sticky flag
//   Ovf_count             : released entries with overflow, saturating
//   Level                 : FIFO occupancy
module sum_accumulator
  import adder_pkg::*;
#(
  parameter  int unsigned DATA_W = DATA_W_DEF,
  parameter  int unsigned ACC_W  = ACC_W_DEF,
  parameter  int unsigned DEPTH  = DEPTH_DEF,
  localparam int unsigned LVL_W  = $clog2(DEPTH) + 1
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              In_valid,
  input  logic [DATA_W-1:0] Sum,
  input  logic              Overflow,
  output logic              In_ready,
  output logic              Out_valid,
  input  logic              Out_ready,
  output logic [DATA_W-1:0] Out_sum,
  output logic              Out_ovf,
  input  logic              Clr,
  output logic [ACC_W-1:0]  Acc,
  output logic              Acc_sat,
  output logic [OVF_W-1:0]  Ovf_count,
  output logic [LVL_W-1:0]  Level
);

  localparam int unsigned SUM_W = ACC_W + 1;

  entry_t           wr_entry;
  entry_t           head_c;
  logic             push, pop;
  logic [SUM_W-1:0] acc_sum_c;

  assign wr_entry = '{ovf: Overflow, sum: Sum};
  assign push     = In_valid && In_ready;
  assign pop      = Out_valid && Out_ready;
  assign Out_sum  = head_c.sum;
  assign Out_ovf  = head_c.ovf;

  result_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (Clk),
    .rst_n       (Rst_n),
    .push        (push),
    .pop         (pop),
    .wr_entry    (wr_entry),
    .rd_entry_c  (head_c),
    .not_full_c  (In_ready),
    .not_empty_c (Out_valid),
    .level       (Level)
  );

  // One extra bit catches the carry that signals saturation
  assign acc_sum_c = {1'b0, Acc} + SUM_W'(Out_sum);

  // Statistics; Clr wins but still counts a pop in the same cycle
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      Acc       <= '0;
      Acc_sat   <= 1'b0;
      Ovf_count <= '0;
    end else if (Clr) begin
      Acc       <= pop ? ACC_W'(Out_sum) : '0;
      Acc_sat   <= 1'b0;
      Ovf_count <= (pop && Out_ovf) ? OVF_W'(1) : '0;
    end else if (pop) begin
      if (acc_sum_c[ACC_W]) begin
        Acc     <= '1;
        Acc_sat <= 1'b1;
      end else begin
        Acc <= acc_sum_c[ACC_W-1:0];
      end
      if (Out_ovf && (Ovf_count != '1)) begin
        Ovf_count <= Ovf_count + OVF_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_sum_accumulator.sv
// Self-checking bench for sum_accumulator: directed scenarios plus random
// traffic, compared against a queue-based reference model.
module tb_sum_accumulator;

  localparam int DEPTH   = 4;
  localparam int ACC_MAX = 255;
  localparam int OVF_MAX = 15;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] sum;
  logic       overflow;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_sum;
  logic       out_ovf;
  logic       clr;
  logic [7:0] acc;
  logic       acc_sat;
  logic [3:0] ovf_count;
  logic [2:0] level;

  typedef struct {
    int sum;
    int ovf;
  } ent_t;

  ent_t q[$];
  int   m_acc, m_sat, m_ovfc;
  int   n_tests, n_fail;

  sum_accumulator dut (
    .Clk       (clk),
    .Rst_n     (rst_n),
    .In_valid  (in_valid),
    .Sum       (sum),
    .Overflow  (overflow),
    .In_ready  (in_ready),
    .Out_valid (out_valid),
    .Out_ready (out_ready),
    .Out_sum   (out_sum),
    .Out_ovf   (out_ovf),
    .Clr       (clr),
    .Acc       (acc),
    .Acc_sat   (acc_sat),
    .Ovf_count (ovf_count),
    .Level     (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check("in_ready", int'(in_ready), int'(q.size() < DEPTH));
    check("out_valid", int'(out_valid), int'(q.size() > 0));
    check("level", int'(level), q.size());
    check("acc", int'(acc), m_acc);
    check("acc_sat", int'(acc_sat), m_sat);
    check("ovf_count", int'(ovf_count), m_ovfc);
    if (q.size() > 0) begin
      check("out_sum", int'(out_sum), q[0].sum);
      check("out_ovf", int'(out_ovf), q[0].ovf);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_acc  = 0;
    m_sat  = 0;
    m_ovfc = 0;
  endtask

  // Check outputs at the falling edge, then drive one cycle of inputs and
  // advance the model to what the next rising edge should produce.
  task automatic step(input bit iv, input int s, input bit o, input bit ordy, input bit c);
    bit   do_push;
    bit   do_pop;
    ent_t h;
    @(negedge clk);
    check_outputs();
    in_valid  = iv;
    sum       = 4'(s);
    overflow  = o;
    out_ready = ordy;
    clr       = c;
    do_push = iv && (q.size() < DEPTH);
    do_pop  = ordy && (q.size() > 0);
    h = '{0, 0};
    if (do_pop) h = q[0];
    if (c) begin
      m_acc  = do_pop ? h.sum : 0;
      m_sat  = 0;
      m_ovfc = (do_pop && h.ovf != 0) ? 1 : 0;
    end else if (do_pop) begin
      if (m_acc + h.sum > ACC_MAX) begin
        m_acc = ACC_MAX;
        m_sat = 1;
      end else begin
        m_acc = m_acc + h.sum;
      end
      if (h.ovf != 0 && m_ovfc < OVF_MAX) m_ovfc++;
    end
    if (do_pop) void'(q.pop_front());
    if (do_push) q.push_back('{s & 15, int'(o)});
  endtask

  task automatic drain();
    for (int g = 0; g < 16 && q.size() > 0; g++) step(0, 0, 0, 1, 0);
    check("drained", q.size(), 0);
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    sum       = '0;
    overflow  = 1'b0;
    out_ready = 1'b0;
    clr       = 1'b0;
    model_reset();

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_sum", int'(out_sum), 0);
    check("rst_out_ovf", int'(out_ovf), 0);
    check("rst_level", int'(level), 0);
    check("rst_acc", int'(acc), 0);
    rst_n = 1'b1;

    // Single result with overflow passes straight through
    step(1, 4, 1, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    check("t1_acc", int'(acc), 4);
    check("t1_ovfc", int'(ovf_count), 1);
    check("t1_level", int'(level), 0);

    // Fill to FULL, fifth push dropped, then drain in order
    step(0, 0, 0, 0, 1);
    for (int i = 1; i <= 5; i++) step(1, i, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    check("t2_in_ready_full", int'(in_ready), 0);
    check("t2_level_full", int'(level), 4);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    check("t2_acc", int'(acc), 10);
    check("t2_level_empty", int'(level), 0);

    // Streaming at full rate saturates the accumulator
    for (int i = 0; i < 20; i++) step(1, 15, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    check("t3_acc_sat_val", int'(acc), 255);
    check("t3_acc_sat_flag", int'(acc_sat), 1);
    drain();

    // Overflow counter saturates; clear with a simultaneous pop
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 16; i++) step(1, 0, 1, 1, 0);
    step(1, 3, 0, 1, 0);
    step(0, 0, 0, 1, 1);
    check("t4_ovf_sat", int'(ovf_count), 15);
    step(0, 0, 0, 0, 0);
    check("t4_clr_acc", int'(acc), 3);
    check("t4_clr_sat", int'(acc_sat), 0);
    check("t4_clr_ovfc", int'(ovf_count), 0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(bit'($urandom_range(0, 3) != 0), int'($urandom_range(0, 15)),
           bit'($urandom_range(0, 1)), bit'($urandom_range(0, 2) != 0),
           bit'($urandom_range(0, 15) == 0));
    end
    drain();

    // Asynchronous reset mid-cycle with entries and statistics present
    step(0, 0, 0, 0, 1);
    step(1, 7, 1, 1, 0);
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 9, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    check("t5_level_pre", int'(level), 3);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("t5_in_ready", int'(in_ready), 1);
    check("t5_out_valid", int'(out_valid), 0);
    check("t5_level", int'(level), 0);
    check("t5_acc", int'(acc), 0);
    check("t5_ovfc", int'(ovf_count), 0);
    check("t5_out_sum", int'(out_sum), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step(bit'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
           bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 1'b0);
    end
    step(0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sum_accumulator.md
# sum_accumulator

Downstream consumer of the 4-bit adder stage. It captures each valid `Sum`/`Overflow` result into a 4-deep FIFO and releases entries to a consumer over a valid/ready handshake. On every released entry it folds the result into a saturating 8-bit running total and a saturating overflow counter. It decouples the adder's fixed-rate output from a slower checker or display stage and provides aggregate statistics for bench self-checking.

## Interface
- `DATA_W`, 4, width of adder `Sum`
- `ACC_W`, 8, width of running accumulator
- `DEPTH`, 4, FIFO entries (power of two, ≥2)
- `Clk`  in  1  rising-edge clock
- `Rst_n`  in  1  asynchronous, active-low reset
- `In_valid`  in  1  adder result present (driven from adder `En`)
- `Sum`  in  DATA_W  adder sum
- `Overflow`  in  1  adder carry/overflow
- `In_ready`  out  1  FIFO can accept an entry
- `Out_valid`  out  1  head entry present
- `Out_ready`  in  1  consumer accepts head
- `Out_sum`  out  DATA_W  head sum
- `Out_ovf`  out  1  head overflow flag
- `Clr`  in  1  synchronous clear of statistics
- `Acc`  out  ACC_W  running total of released sums
- `Acc_sat`  out  1  sticky: `Acc` saturated
- `Ovf_count`  out  4  released entries with overflow, saturating at 15
- `Level`  out  clog2(DEPTH)+1  FIFO occupancy

## Operation
- Push: `In_valid && In_ready` writes {`Overflow`, `Sum`} at the write pointer.
- Pop: `Out_valid && Out_ready` advances the read pointer.
- `In_ready = (state != FULL)`.
- `Out_valid = (state != EMPTY)`.
- `Out_sum`/`Out_ovf` show the head entry combinationally from storage (first-word fall-through).
- Occupancy FSM, explicit encoding:
  - EMPTY → MID on push.
  - MID → FULL on push-only when `Level == DEPTH-1`.
  - MID → EMPTY on pop-only when `Level == 1`.
  - FULL → MID on pop.
  - Simultaneous push+pop in MID: state and `Level` unchanged.
- Pointers wrap modulo DEPTH.
- Push while FULL: dropped. `In_ready` is 0, so the upstream must hold.
- Pop while EMPTY: no effect.
- On pop:
  - `Acc <= min(Acc + zero-extended Out_sum, 2^ACC_W-1)`.
  - If the sum would exceed `2^ACC_W-1`, `Acc_sat <= 1`, and it stays set until cleared.
  - If `Out_ovf`, `Ovf_count` increments, saturating at 15.
- `Clr`:
  - Has priority over accumulation.
  - `Acc <= (pop ? Out_sum : 0)`, `Acc_sat <= 0`.
  - `Ovf_count <= (pop && Out_ovf) ? 1 : 0`.
  - FIFO contents are untouched.

## Timing
- Reset (asynchronous assert, synchronous use after release):
  - state EMPTY, pointers 0, `Level` 0.
  - `Acc` 0, `Acc_sat` 0, `Ovf_count` 0.
  - `Out_valid` 0, `Out_sum` 0, `Out_ovf` 0 (storage cleared).
  - `In_ready` 1.
- Push to `Out_valid`: 1 cycle. An entry pushed at edge N is visible after edge N.
- Pop to statistics: `Acc`/`Ovf_count` reflect a pop at edge N after edge N.
- Throughput: one push and one pop per cycle.
- Full-to-ready latency: a pop at edge N raises `In_ready` after edge N. There is no combinational path from `Out_ready` to `In_ready`.
- Reset mid-stream discards all entries and statistics immediately.

## Structure
- Package `adder_pkg`:
  - `DATA_W` and `ACC_W` defaults.
  - entry typedef {ovf, sum}.
  - FSM state enum {EMPTY, MID, FULL}.
- Sub-module `result_fifo`: storage, pointers, occupancy FSM, `Level`.
- Top `sum_accumulator`: handshake glue plus the saturating accumulator and counter.

## Test plan
- Reset, then drive `In_valid=1`, `Sum=4`, `Ovf=1` (adder A=5, B=15) for one cycle with `Out_ready=1` → `Out_valid` high one cycle later with `Out_sum=4`, `Out_ovf=1`; after the pop, `Acc=4`, `Ovf_count=1`, `Level` back to 0.
- `Out_ready=0`, push 5 entries (Sum 1..5) → `In_ready` falls after the 4th; the 5th is not accepted; `Level=4`; FULL. Then pop 4 → `Out_sum` 1,2,3,4 in order, `Acc=10`.
- Continuous push+pop for 20 cycles, `Sum=15` → `Level` constant at 1 after the first cycle; `Acc` reaches 255, `Acc_sat=1`, then holds 255.
- 16 popped entries with `Ovf=1` → `Ovf_count` saturates at 15. Then `Clr` with a simultaneous pop of `Sum=3`, `Ovf=0` → `Acc=3`, `Acc_sat=0`, `Ovf_count=0`.
- Assert `Rst_n=0` asynchronously mid-clock with `Level=3` → all outputs go to reset values immediately; `In_ready=1`, `Out_valid=0`.
